// File: rtl/pico_controller_tx.sv
// Controller-side PICO transmitter: shifts an address byte plus N data bytes out MSB first
// on sclk/serial_out, then holds a low gap. Optional POCI readback capture under POCI_CAPTURE_EN.
module pico_controller_tx #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 10,
    parameter int NB_W       = 4
) (
    input  logic            iclk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      addr,
    input  logic [NB_W-1:0] nbytes,
    input  logic [7:0]      tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic            sclk,
    output logic            serial_out,
    input  logic            poci,
    output logic [7:0]      rx_data,
    output logic            rx_valid,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        GAP  = 2'd3
    } state_t;

    // One counter times both the sclk half-periods and the trailing gap.
    localparam int CNT_MAX = (GAP_CYCLES > CLK_DIV) ? GAP_CYCLES : CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PHASE_END = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP_CYCLES - 1);

    state_t          state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]      bit_idx_reg, bit_idx_next;
    logic [NB_W-1:0] bytes_left_reg, bytes_left_next;
    logic [7:0]      byte_reg, byte_next;
    logic            abort_reg, abort_next;
    logic            err_reg, err_next;

    logic phase_end;
    logic gap_end;
    logic more_bytes;
    logic last_bit_cycle;
    logic accept;

    assign phase_end      = (cnt_reg == PHASE_END);
    assign gap_end        = (cnt_reg == GAP_END);
    assign more_bytes     = (bytes_left_reg != '0);
    assign last_bit_cycle = (state_reg == HIGH) && phase_end && (bit_idx_reg == 3'd0);
    assign accept         = (state_reg == IDLE) && start && (addr != 8'h00);

    always_ff @(posedge iclk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= 3'd0;
            bytes_left_reg <= '0;
            byte_reg       <= 8'h00;
            abort_reg      <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            bytes_left_reg <= bytes_left_next;
            byte_reg       <= byte_next;
            abort_reg      <= abort_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        bit_idx_next    = bit_idx_reg;
        bytes_left_next = bytes_left_reg;
        byte_next       = byte_reg;
        abort_next      = abort_reg;
        err_next        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next      = LOW;
                    cnt_next        = '0;
                    bit_idx_next    = 3'd7;
                    bytes_left_next = nbytes;
                    byte_next       = addr;
                    abort_next      = 1'b0;
                end else if (start) begin
                    // Address 0 means "no address" to the peripheral.
                    err_next = 1'b1;
                end
            end
            LOW: begin
                if (phase_end) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    cnt_next = '0;
                    if (bit_idx_reg != 3'd0) begin
                        bit_idx_next = bit_idx_reg - 1'b1;
                        state_next   = LOW;
                    end else if (more_bytes) begin
                        if (tx_valid) begin
                            byte_next       = tx_data;
                            bytes_left_next = bytes_left_reg - 1'b1;
                            bit_idx_next    = 3'd7;
                            state_next      = LOW;
                        end else begin
                            // Underrun: still run the gap so the peripheral resets.
                            abort_next = 1'b1;
                            err_next   = 1'b1;
                            state_next = GAP;
                        end
                    end else begin
                        state_next = GAP;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            GAP: begin
                if (gap_end) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sclk       = (state_reg == HIGH);
    assign serial_out = ((state_reg == LOW) || (state_reg == HIGH)) && byte_reg[bit_idx_reg];
    assign busy       = (state_reg != IDLE);
    assign tx_ready   = last_bit_cycle && more_bytes;
    assign done       = (state_reg == GAP) && gap_end && !abort_reg;
    assign err        = err_reg;

`ifdef POCI_CAPTURE_EN
    logic [7:0] rx_shift_reg;
    logic [7:0] rx_shift_next;
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;
    logic       first_high;

    // With CLK_DIV=1 the sample and the byte hand-off share a cycle, so hand off the shifted value.
    assign first_high    = (state_reg == HIGH) && (cnt_reg == '0);
    assign rx_shift_next = first_high ? {rx_shift_reg[6:0], poci} : rx_shift_reg;

    always_ff @(posedge iclk) begin
        if (rst) begin
            rx_shift_reg <= 8'h00;
            rx_data_reg  <= 8'h00;
            rx_valid_reg <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            if (accept) begin
                rx_shift_reg <= 8'h00;
            end else begin
                rx_shift_reg <= rx_shift_next;
            end
            if (last_bit_cycle) begin
                rx_data_reg  <= rx_shift_next;
                rx_valid_reg <= 1'b1;
            end
        end
    end

    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
`else
    logic unused_poci;

    assign unused_poci = poci;
    assign rx_data     = 8'h00;
    assign rx_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_pico_controller_tx.sv
// Randomized bench for pico_controller_tx: reconstructs bytes, timing and handshakes from the pins
// and compares them with expectations computed from the transaction parameters.
module tb_pico_controller_tx;
    localparam int CLK_DIV    = 2;
    localparam int GAP_CYCLES = 10;
    localparam int NB_W       = 4;
    localparam int BYTE_CYC   = 16 * CLK_DIV;

    logic            iclk = 1'b0;
    logic            rst;
    logic            start;
    logic [7:0]      addr;
    logic [NB_W-1:0] nbytes;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            sclk;
    logic            serial_out;
    logic            poci;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            busy;
    logic            done;
    logic            err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 iclk = ~iclk;

    pico_controller_tx #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES),
        .NB_W       (NB_W)
    ) dut (
        .iclk       (iclk),
        .rst        (rst),
        .start      (start),
        .addr       (addr),
        .nbytes     (nbytes),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .sclk       (sclk),
        .serial_out (serial_out),
        .poci       (poci),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one transaction starting at the current negedge; returns at the first negedge with busy=0.
    task automatic run_txn(input logic [7:0] a, input int n, input int underrun_at,
                           input int poke_cyc, input bit hold_at_done, input bit ramp);
        logic [7:0] data_q[$];
        logic       bits_q[$];
        logic       poci_q[$];
        logic [7:0] rx_q[$];
        int   cyc, n_rdy, n_done, n_err, n_rxv, rx_nonzero, done_cyc;
        int   low_run, hi_len, bad_width, unstable, sent, exp_len;
        logic prev_sclk, hi_val;
        bit   aborted, timed_out;
        n_rdy = 0; n_done = 0; n_err = 0; n_rxv = 0; rx_nonzero = 0; done_cyc = 0;
        low_run = 0; hi_len = 0; bad_width = 0; unstable = 0;
        prev_sclk = 1'b0; hi_val = 1'b0; timed_out = 1'b0;
        for (int i = 0; i < n; i++)
            data_q.push_back(ramp ? 8'(8'h11 * (i + 1)) : 8'($urandom));
        start  = 1'b1;
        addr   = a;
        nbytes = NB_W'(n);
        @(negedge iclk);
        start  = 1'b0;
        addr   = 8'($urandom);
        nbytes = NB_W'($urandom);
        chk("first_busy", busy, 1);
        chk("first_sclk", sclk, 0);
        chk("first_bit", serial_out, a[7]);
        cyc = 1;
        while (busy) begin
            poci = 1'($urandom);
            if (sclk && !prev_sclk) begin
                bits_q.push_back(serial_out);
                poci_q.push_back(poci);
                hi_val = serial_out;
                hi_len = 0;
            end
            if (sclk) begin
                hi_len++;
                if (serial_out !== hi_val) unstable++;
                low_run = 0;
            end else begin
                if (prev_sclk && hi_len != CLK_DIV) bad_width++;
                low_run++;
            end
            if (done) begin n_done++; done_cyc = cyc; end
            if (err) n_err++;
            if (rx_valid) begin n_rxv++; rx_q.push_back(rx_data); end
            if (rx_data != 8'h00) rx_nonzero++;
            start = 1'b0;
            if (cyc == poke_cyc) begin
                start  = 1'b1;
                addr   = 8'($urandom);
                nbytes = NB_W'($urandom);
            end
            if (done && hold_at_done) begin
                start = 1'b1;
                addr  = 8'($urandom_range(1, 255));
            end
            if (tx_ready) begin
                tx_valid = (n_rdy != underrun_at);
                tx_data  = (n_rdy < n) ? data_q[n_rdy] : 8'($urandom);
                n_rdy++;
            end else begin
                tx_valid = 1'($urandom);
                tx_data  = 8'($urandom);
            end
            prev_sclk = sclk;
            @(negedge iclk);
            cyc++;
            if (cyc > 2000) begin timed_out = 1'b1; break; end
        end
        aborted = (underrun_at >= 0) && (underrun_at < n);
        sent    = aborted ? underrun_at + 1 : n + 1;
        exp_len = sent * BYTE_CYC + GAP_CYCLES;
        chk("timeout", timed_out, 0);
        chk("nbits", bits_q.size(), 8 * sent);
        for (int b = 0; b < sent; b++) begin
            logic [7:0] exp_b, got_b;
            exp_b = (b == 0) ? a : data_q[b - 1];
            got_b = 8'h00;
            for (int k = 0; k < 8; k++)
                if (8 * b + k < bits_q.size()) got_b = {got_b[6:0], bits_q[8 * b + k]};
            chk($sformatf("byte%0d", b), got_b, exp_b);
        end
        chk("tx_ready_cnt", n_rdy, aborted ? underrun_at + 1 : n);
        chk("done_cnt", n_done, aborted ? 0 : 1);
        chk("err_cnt", n_err, aborted ? 1 : 0);
        chk("busy_len", cyc - 1, exp_len);
        if (!aborted) chk("done_cyc", done_cyc, exp_len);
        chk("gap_len", low_run, GAP_CYCLES);
        chk("high_width", bad_width, 0);
        chk("hold_stable", unstable, 0);
`ifdef POCI_CAPTURE_EN
        chk("rx_cnt", n_rxv, sent);
        for (int b = 0; b < sent; b++) begin
            logic [7:0] exp_r;
            exp_r = 8'h00;
            for (int k = 0; k < 8; k++)
                if (8 * b + k < poci_q.size()) exp_r = {exp_r[6:0], poci_q[8 * b + k]};
            if (b < rx_q.size()) chk($sformatf("rx%0d", b), rx_q[b], exp_r);
        end
`else
        chk("rx_valid_cnt", n_rxv, 0);
        chk("rx_data_zero", rx_nonzero, 0);
`endif
        $display("txn addr=%02h nbytes=%0d underrun=%0d sent=%0d busy_cycles=%0d done=%0d err=%0d",
                 a, n, underrun_at, sent, cyc - 1, n_done, n_err);
    endtask

    task automatic rejected_start();
        start = 1'b1;
        addr  = 8'h00;
        nbytes = NB_W'(2);
        @(negedge iclk);
        start = 1'b0;
        chk("rej_err", err, 1);
        chk("rej_busy", busy, 0);
        @(negedge iclk);
        chk("rej_err_clear", err, 0);
        chk("rej_busy_after", busy, 0);
        $display("txn rejected start addr=00");
    endtask

    task automatic reset_mid_byte();
        int   rises, guard, n_evt;
        logic prev;
        rises = 0; guard = 0; n_evt = 0; prev = 1'b0;
        start    = 1'b1;
        addr     = 8'($urandom_range(1, 255));
        nbytes   = NB_W'($urandom_range(0, 3));
        tx_valid = 1'b1;
        @(negedge iclk);
        start = 1'b0;
        while (guard < 500) begin
            if (sclk && !prev) rises++;
            if (rises == 4 && sclk) break;
            prev = sclk;
            @(negedge iclk);
            guard++;
        end
        chk("rst_reach_bit4", rises, 4);
        rst = 1'b1;
        @(negedge iclk);
        rst = 1'b0;
        chk("rst_sclk", sclk, 0);
        chk("rst_serial_out", serial_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 0);
        for (int i = 0; i < 20; i++) begin
            if (done || err || busy) n_evt++;
            @(negedge iclk);
        end
        chk("rst_no_pulses", n_evt, 0);
        $display("txn reset during bit 4 high phase");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; addr = 8'h00; nbytes = '0;
        tx_data = 8'h00; tx_valid = 1'b0; poci = 1'b0;
        repeat (3) @(negedge iclk);
        rst = 1'b0;
        @(negedge iclk);
        chk("reset_sclk", sclk, 0);
        chk("reset_serial_out", serial_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_tx_ready", tx_ready, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_data", rx_data, 0);

        rejected_start();
        reset_mid_byte();

        run_txn(8'hA5, 0, -1, 0, 1'b0, 1'b0);
        run_txn(8'h10, 3, -1, 12, 1'b0, 1'b1);
        run_txn(8'($urandom_range(1, 255)), 2, 1, 0, 1'b0, 1'b0);
        run_txn(8'h20, 1, -1, 0, 1'b1, 1'b0);
        run_txn(8'h21, 1, -1, 0, 1'b0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            int n, ur, pk;
            bit hold;
            n    = $urandom_range(0, 5);
            ur   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
            pk   = ($urandom_range(0, 1) == 1) ? $urandom_range(3, 30) : 0;
            hold = 1'($urandom);
            run_txn(8'($urandom_range(1, 255)), n, ur, pk, hold, 1'b0);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge iclk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
